// File: rtl/load_store_unit.sv
// Load/store unit for the Memory stage: turns a load or store into a single
// word-addressed bus transaction, stalls the pipeline while it is outstanding,
// and aligns/extends load data into the writeback register.
// Lane logic assumes a 32-bit data path (four byte lanes on mem_be).
module load_store_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Timer holds 0..ACK_TIMEOUT-1, one count per BUSY cycle.
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [TW-1:0]         r_timer;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_bus_err;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_be;
  logic                  r_is_load;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lane;

  logic                  w_access;
  logic                  w_is_store;
  logic                  w_size_byte;
  logic                  w_size_half;
  logic                  w_size_word;
  logic                  w_misalign;
  logic                  w_start;
  logic                  w_timeout;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_shift;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [DATA_WIDTH-1:0] w_load_ext;

  // A store wins when both strobes are set; undefined sizes fall back to word.
  assign w_access    = MemReadM | MemWriteM;
  assign w_is_store  = MemWriteM;
  assign w_size_byte = (Funct3M[1:0] == 2'b00);
  assign w_size_half = (Funct3M[1:0] == 2'b01);
  assign w_size_word = ~(w_size_byte | w_size_half);
  assign w_misalign  = (w_size_half & ALUResultM[0]) |
                       (w_size_word & (ALUResultM[1:0] != 2'b00));
  assign w_start     = (r_state == S_IDLE) & w_access & ~w_misalign;
  assign w_timeout   = (r_state == S_BUSY) & ~mem_ack & (r_timer == TIMER_LAST);

  // Byte enables and lane-replicated store data for the request being issued.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    if (w_is_store) begin
      if (w_size_byte) begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end else if (w_size_half) begin
        w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM[15:0]}};
      end
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  assign w_rd_shift = mem_rdata >> {r_lane, 3'b000};
  assign w_rd_byte  = w_rd_shift[7:0];
  assign w_rd_half  = w_rd_shift[15:0];

  // Sign/zero extension chosen by the latched access type.
  always_comb begin
    w_load_ext = mem_rdata;
    case (r_funct3)
      3'b000:  w_load_ext = {{(DATA_WIDTH-8){w_rd_byte[7]}}, w_rd_byte};
      3'b001:  w_load_ext = {{(DATA_WIDTH-16){w_rd_half[15]}}, w_rd_half};
      3'b100:  w_load_ext = {{(DATA_WIDTH-8){1'b0}}, w_rd_byte};
      3'b101:  w_load_ext = {{(DATA_WIDTH-16){1'b0}}, w_rd_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: one request, then a single release cycle in DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_BUSY;
      S_BUSY:  if (mem_ack || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Stall is raised in the issue cycle itself so the pipeline never slips.
  always_comb begin
    StallM    = ~reset & (w_start | (r_state == S_BUSY));
    MisalignM = w_access & w_misalign;
  end

  // Bus request registers, timeout timer and load result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer     <= '0;
      r_read_data <= '0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'b0000;
      r_is_load   <= 1'b0;
      r_funct3    <= 3'b000;
      r_lane      <= 2'b00;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_is_load   <= ~w_is_store;
            r_funct3    <= Funct3M;
            r_lane      <= ALUResultM[1:0];
            r_timer     <= '0;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_is_load) r_read_data <= w_load_ext;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_bus_err <= 1'b1;
            if (r_is_load) r_read_data <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReadDataM = r_read_data;
  assign BusErrM   = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, max BUSY cycles waiting for mem_ack before bus error.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MemReadM  input  1  load in Memory stage.
REQ-006 MemWriteM  input  1  store in Memory stage.
REQ-007 Funct3M  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
REQ-008 ALUResultM  input  DATA_WIDTH  byte address.
REQ-009 WriteDataM  input  DATA_WIDTH  store data, right-aligned.
REQ-010 ReadDataM  output  DATA_WIDTH  registered, extended load result to writeback register.
REQ-011 StallM  output  1  freeze of F/D/E/M stages while access outstanding.
REQ-012 MisalignM  output  1  combinational, misaligned access in M.
REQ-013 BusErrM  output  1  one-cycle pulse on ack timeout.
REQ-014 mem_req, mem_we  output  1 each  bus request and write strobe.
REQ-015 mem_addr  output  DATA_WIDTH  word address, bits [1:0] forced 0.
REQ-016 mem_wdata  output  DATA_WIDTH, mem_be  output  4  lane-replicated store data, byte enables.
REQ-017 mem_ack  input  1, mem_rdata  input  DATA_WIDTH  completion strobe and read word.

Function
REQ-018 SHALL implement FSM IDLE, BUSY, DONE.
REQ-019 Access = MemReadM|MemWriteM; both set SHALL be treated as store only.
REQ-020 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; SHALL set MisalignM, issue no request, keep StallM=0, leave ReadDataM unchanged.
REQ-021 IDLE, aligned access: StallM=1 combinationally same cycle; next state BUSY; mem_* outputs registered at that edge.
REQ-022 BUSY: mem_req=1; mem_addr/mem_we/mem_be/mem_wdata SHALL be stable until ack; StallM=1.
REQ-023 BUSY with mem_ack=1: for loads, capture extended data into ReadDataM; drop mem_req; go DONE; same-cycle ack (1 BUSY cycle) SHALL be legal.
REQ-024 BUSY timer counts BUSY cycles; at ACK_TIMEOUT without ack: BusErrM=1 for one cycle, ReadDataM<=0 for loads, go DONE.
REQ-025 DONE: StallM=0 for exactly one cycle so the pipeline advances; no new request accepted; next state IDLE.
REQ-026 Minimum access latency: 3 cycles (IDLE->BUSY->DONE) with ack on first BUSY cycle.
REQ-027 Byte enables: sb 1<<addr[1:0]; sh 0011 (addr[1]=0) or 1100; sw 1111; loads 1111.
REQ-028 mem_wdata: sb byte replicated x4; sh half replicated x2; sw unchanged.
REQ-029 Loads: lane chosen by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
REQ-030 Undefined Funct3M (011, 110, 111) SHALL be treated as word access.
REQ-031 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-032 reset=1 at a rising edge: state IDLE, timer 0, ReadDataM 0, mem_req/mem_we 0, mem_be 0, BusErrM 0.
REQ-033 Reset mid-BUSY SHALL drop mem_req on that edge; a later ack SHALL have no effect.
REQ-034 StallM SHALL be 0 while reset is asserted.

Verification
REQ-035 lw addr 0x100, ack on 2nd BUSY cycle, rdata 0xDEADBEEF -> StallM high 3 cycles, ReadDataM=0xDEADBEEF, mem_be=1111.
REQ-036 lb addr 0x103, rdata 0x80112233 -> ReadDataM=0xFFFFFF80; lbu same -> 0x00000080.
REQ-037 sh addr 0x202, WriteDataM 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, mem_addr=0x200.
REQ-038 lw addr 0x101 -> MisalignM=1, mem_req never asserted, StallM=0.
REQ-039 lw, no ack -> BusErrM pulses after 16 BUSY cycles, ReadDataM=0, FSM back to IDLE via DONE.
REQ-040 reset during BUSY, ack one cycle later -> mem_req=0, ReadDataM=0, state IDLE.
